// File: rtl/adder_operand_queue.sv
// Operand queue feeding the 32-bit combinational adder.
// Buffers (a, b, cin) triples behind a valid/ready handshake and presents the
// head triple on op_a/op_b/op_cin, held stable until the consumer accepts it.
// Optional build macro ADDER_OPQ_FALLTHROUGH_EN: when the queue is empty, an
// offered triple is presented combinationally in the same cycle and, if it is
// accepted at once, it bypasses storage entirely.
module adder_operand_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic             mem_cin [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic empty;
  logic push;
  logic wr_en;
  logic pop_mem;
  logic bypass;

  assign empty    = (count_q == '0);
  // Purely state-based: no path from op_ready into in_ready.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef ADDER_OPQ_FALLTHROUGH_EN
  assign bypass  = empty & in_valid;
  // A triple taken straight through while empty is never written.
  assign wr_en   = push & ~(bypass & op_ready);
  assign pop_mem = ~empty & op_ready;
`else
  assign bypass  = 1'b0;
  assign wr_en   = push;
  assign pop_mem = ~empty & op_ready;
`endif

  // Head presentation: bypass path, stored head, or zeros when nothing is held.
  always_comb begin
    op_valid = ~empty | bypass;
    op_a     = '0;
    op_b     = '0;
    op_cin   = 1'b0;
    if (bypass) begin
      op_a   = in_a;
      op_b   = in_b;
      op_cin = in_cin;
    end else if (!empty) begin
      op_a   = mem_a[rd_ptr_q];
      op_b   = mem_b[rd_ptr_q];
      op_cin = mem_cin[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_mem) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_en, pop_mem})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with synchronous reset; storage is left untouched by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry write; suppressed during reset so a flushed push leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_a[wr_ptr_q]   <= in_a;
      mem_b[wr_ptr_q]   <= in_b;
      mem_cin[wr_ptr_q] <= in_cin;
    end
  end

endmodule

// File: tb/tb_adder_operand_queue.sv
// Scoreboard bench for adder_operand_queue (default build, DEPTH=4).
module tb_adder_operand_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected triples in acceptance order, packed {a, b, cin}.
  logic [2*WIDTH:0] sb[$];

  adder_operand_queue #(
    .WIDTH(WIDTH),
    .DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_cin  (in_cin),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_cin  (op_cin),
    .count   (count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the scoreboard front.
  always @(negedge clk) begin
    logic [2*WIDTH:0] exp;
    if (!rst && op_valid && op_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got a=%0h b=%0h cin=%0b expected none", op_a, op_b,
                 op_cin);
      end else begin
        exp = sb.pop_front();
        if ({op_a, op_b, op_cin} !== exp) begin
          n_fail++;
          $display("FAIL head_order: got a=%0h b=%0h cin=%0b expected a=%0h b=%0h cin=%0b",
                   op_a, op_b, op_cin, exp[2*WIDTH:WIDTH+1], exp[WIDTH:1], exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Offer a triple for one cycle; accepted ones go to the scoreboard.
  task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       input logic accept);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    if (accept) sb.push_back({a, b, c});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    op_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sb.size() == 0) break;
    end
    at_neg();
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({name, "_count0"}, 64'(count), 64'd0);
  endtask

  initial begin
    logic [32:0] sum;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    op_ready = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    at_neg();
    check("rst_op_valid", 64'(op_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_op_a", 64'(op_a), 64'd0);
    check("rst_op_b", 64'(op_b), 64'd0);
    check("rst_op_cin", 64'(op_cin), 64'd0);

    // Single push, one-cycle latency, adder result 0 carry 1
    op_ready = 1'b1;
    offer(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1);
    at_neg();
    check("single_op_valid", 64'(op_valid), 64'd1);
    sum = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
    check("single_adder", 64'(sum), 64'h1_0000_0000);
    tick();
    at_neg();
    check("single_empty_valid", 64'(op_valid), 64'd0);
    check("single_empty_count", 64'(count), 64'd0);

    // Fill, overflow attempt, drain in order
    op_ready = 1'b0;
    for (int i = 1; i <= 4; i++) offer(32'(i), 32'h0, 1'b0, 1'b1);
    at_neg();
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_no_ovf_yet", 64'(overflow), 64'd0);
    offer(32'd5, 32'h0, 1'b0, 1'b0);
    at_neg();
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    drain("fill");
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Streaming with continuous accept
    do_reset();
    op_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i);
      in_b     = 32'(i) << 16;
      in_cin   = i[0];
      sb.push_back({in_a, in_b, in_cin});
      tick();
      at_neg();
      check("stream_count", 64'(count), 64'd1);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    drain("stream");
    check("stream_no_ovf", 64'(overflow), 64'd0);

    // Backpressure hold on the head
    do_reset();
    op_ready = 1'b0;
    offer(32'hDEAD_BEEF, 32'h1, 1'b1, 1'b1);
    at_neg();
    check("hold_count1", 64'(count), 64'd1);
    check("hold_op_a", 64'(op_a), 64'hDEAD_BEEF);
    offer(32'h11, 32'h2, 1'b0, 1'b1);
    at_neg();
    check("hold_op_a", 64'(op_a), 64'hDEAD_BEEF);
    offer(32'h22, 32'h3, 1'b1, 1'b1);
    at_neg();
    check("hold_count3", 64'(count), 64'd3);
    for (int k = 0; k < 2; k++) begin
      tick();
      at_neg();
      check("hold_op_a", 64'(op_a), 64'hDEAD_BEEF);
      check("hold_op_b", 64'(op_b), 64'h1);
      check("hold_op_cin", 64'(op_cin), 64'd1);
    end
    drain("hold");

    // Mid-operation reset with count=3 and overflow set
    op_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(32'hA + 32'(i), 32'h0, 1'b1, 1'b1);
    offer(32'hE, 32'h0, 1'b0, 1'b0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    at_neg();
    check("mid_count3", 64'(count), 64'd3);
    check("mid_ovf", 64'(overflow), 64'd1);
    do_reset();
    at_neg();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(op_valid), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    check("mid_rst_op_a", 64'(op_a), 64'd0);
    offer(32'd7, 32'h9, 1'b0, 1'b1);
    at_neg();
    check("mid_push_op_a", 64'(op_a), 64'd7);
    check("mid_push_count", 64'(count), 64'd1);
    drain("mid");

    // Accept while empty changes nothing
    op_ready = 1'b1;
    tick();
    tick();
    at_neg();
    check("empty_pop_count", 64'(count), 64'd0);
    check("empty_pop_valid", 64'(op_valid), 64'd0);
    op_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
